decode_issue_ctrl: RTL
======================

# decode_issue_ctrl

Issue controller for the decode-to-execute boundary. It tracks in-flight register writes in a scoreboard and holds fetch/decode on RAW or WAW hazards. It inserts a bubble into the decode pipeline buffer instead of a stalled or squashed instruction, and sequences a fixed-length flush after a redirect from execute. It sits beside the decode pipeline buffer and drives that buffer's load and bubble controls.

## Interface
- `NREGS`, 32: architectural registers; register 0 is hardwired zero.
- `FLUSH_CYCLES`, 2: cycles the pipeline is squashed after a redirect (1..15).
- `CNT_W`, 16: width of the stall-cycle performance counter.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `id_valid` input 1: decode holds a valid instruction.
- `rs1`, `rs2` input 5 each: source register indices.
- `rs1_valid`, `rs2_valid` input 1 each: the corresponding source is read.
- `rd` input 5: destination register index.
- `rd_valid` input 1: the instruction writes `rd`.
- `wb_valid` input 1: a writeback retires this cycle.
- `wb_rd` input 5: register retired by writeback.
- `redirect` input 1: execute resolved a taken branch or jump.
- `issue` output 1: decode buffer captures the decode instruction this cycle.
- `bubble` output 1: decode buffer loads an all-zero control word.
- `stall` output 1: fetch and decode hold their current contents.
- `flushing` output 1: the FSM is in FLUSH.
- `stall_cnt` output CNT_W: count of cycles with `stall`=1 (saturating).

## Operation
- Scoreboard: `NREGS` pending bits.
  - Bit 0 is never set.
  - A bit is set on `issue` with `rd_valid` and `rd`≠0.
  - A bit is cleared on `wb_valid` for `wb_rd`.
  - If set and clear hit the same register in the same cycle, set wins.
- Writeback bypass: a register retiring this cycle is treated as not pending for hazard checks, because the register file is write-first.
- `raw` = (`rs1_valid` & `rs1`≠0 & pending(`rs1`)) | (same for `rs2`).
- `waw` = `rd_valid` & `rd`≠0 & pending(`rd`).
- `hazard` = `id_valid` & (`raw` | `waw`).
- Only one write per register may be in flight. The WAW stall guarantees this.
- FSM states:
  - RUN:
    - `redirect` → FLUSH, load flush counter with `FLUSH_CYCLES`-1.
    - else `hazard` → STALL.
    - else stay in RUN.
  - STALL:
    - `redirect` → FLUSH.
    - else `hazard` cleared → RUN.
    - else stay in STALL.
  - FLUSH: the counter decrements each cycle. At 0 → RUN. A `redirect` during FLUSH reloads the counter.
- Outputs (combinational from state and current inputs):
  - RUN or STALL with `redirect`: `issue`=0, `bubble`=1, `stall`=0 (fetch redirects).
  - FLUSH: `issue`=0, `bubble`=1, `stall`=0.
  - `hazard` (no redirect): `issue`=0, `bubble`=1, `stall`=1.
  - `id_valid`=0 (no redirect): `issue`=0, `bubble`=1, `stall`=0.
  - Otherwise: `issue`=1, `bubble`=0, `stall`=0.
- `issue` and `bubble` are never both 1. Exactly one is 1 every cycle out of reset.
- `stall_cnt` increments when `stall`=1 and holds at all-ones.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - FSM in RUN; scoreboard clear; flush counter 0; `stall_cnt` 0.
  - Outputs follow combinationally, giving `issue`=0, `bubble`=1, `stall`=0, `flushing`=0 when `id_valid`=0.
- Hazard detection has zero latency: the decision is made in the same cycle the instruction is in decode.
- Scoreboard updates are visible in the cycle after the edge.
- Minimum RAW stall: an instruction issued in cycle N that writes x5, retiring at writeback cycle W, lets a dependent instruction issue in cycle W via the bypass.
- A flush lasts exactly `FLUSH_CYCLES` bubble cycles after the redirect cycle.
- Asserting reset mid-stall or mid-flush clears everything. In-flight writebacks after reset release are ignored, because clearing an already-clear bit has no effect.

## Structure
- A shared package holds:
  - the FSM state enum (RUN, STALL, FLUSH);
  - the register-index width (5);
  - the zero-register constant.
- One sub-module, `reg_scoreboard`. It holds the pending bit vector with set/clear ports, two read ports plus an rd read port, and the writeback bypass.
- FSM, output decode and the counter live in the top level.

## Test plan
- Independent stream: 4 instructions, no overlaps, `id_valid`=1 → `issue`=1 every cycle, `stall_cnt`=0.
- RAW: issue write to x5; next instruction reads x5 (`rs1`=5); `wb_rd`=5 arrives 3 cycles later → `stall`=1 and `bubble`=1 for 3 cycles, then `issue`=1 in the writeback cycle, `stall_cnt`=3.
- x0 and WAW:
  - An instruction writing x0 followed by one reading x0 → no stall.
  - Two writes to x7 back to back → the second stalls until x7 retires.
- Redirect during stall with `FLUSH_CYCLES`=2 → `flushing`=1 for 2 cycles with `bubble`=1 and `stall`=0, then RUN.
- Redirect during FLUSH → the counter reloads and `flushing` stays 1 for 2 further cycles.
- Same-cycle set and clear on x9 (issue writing x9 while `wb_rd`=9, following a stall) → x9 pending afterward. Then drop `rst` mid-stall → all outputs at reset values and scoreboard empty.

Source files
------------

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types and constants for the decode issue controller.
package decode_issue_ctrl_pkg;

  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned FLUSH_CNT_W = 4;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // A register reference only matters when it is used and is not x0.
  function automatic logic is_live(input logic vld, input logic [REG_IDX_W-1:0] idx);
    return vld && (idx != ZERO_REG);
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Decode/writeback/redirect inputs and buffer controls of the issue controller.
interface decode_issue_ctrl_if
  import decode_issue_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic                 id_valid;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic                 rs1_valid;
  logic                 rs2_valid;
  logic [REG_IDX_W-1:0] rd;
  logic                 rd_valid;
  logic                 wb_valid;
  logic [REG_IDX_W-1:0] wb_rd;
  logic                 redirect;
  logic                 issue;
  logic                 bubble;
  logic                 stall;
  logic                 flushing;
  logic [CNT_W-1:0]     stall_cnt;

  modport master (
    output id_valid, rs1, rs2, rs1_valid, rs2_valid, rd, rd_valid,
           wb_valid, wb_rd, redirect,
    input  issue, bubble, stall, flushing, stall_cnt
  );

  modport slave (
    input  id_valid, rs1, rs2, rs1_valid, rs2_valid, rd, rd_valid,
           wb_valid, wb_rd, redirect,
    output issue, bubble, stall, flushing, stall_cnt
  );

endinterface

// File: rtl/decode_issue_ctrl_reg_scoreboard.sv
// Pending-write bit per architectural register, with write-first writeback bypass.
module reg_scoreboard
  import decode_issue_ctrl_pkg::*;
#(
  parameter int unsigned NREGS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic                 rs1_pend_c,
  output logic                 rs2_pend_c,
  output logic                 rd_pend_c
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  // Clear on writeback, then set on issue so a same-cycle set wins; x0 never pends.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) begin
      pend_d[clr_idx] = 1'b0;
    end
    if (set_en && (set_idx != ZERO_REG)) begin
      pend_d[set_idx] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // A register retiring this cycle reads as not pending (write-first register file).
  assign rs1_pend_c = pend_q[rs1_idx] && !(clr_en && (clr_idx == rs1_idx));
  assign rs2_pend_c = pend_q[rs2_idx] && !(clr_en && (clr_idx == rs2_idx));
  assign rd_pend_c  = pend_q[rd_idx]  && !(clr_en && (clr_idx == rd_idx));

endmodule

// File: rtl/decode_issue_ctrl.sv
// Issue controller: hazard stall, bubble insertion and post-redirect flush sequencing.
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input logic                clk,
  input logic                rst,
  decode_issue_ctrl_if.slave dif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  state_e                 state_q;
  state_e                 state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt_d;
  logic [CNT_W-1:0]       stall_cnt_q;

  logic rs1_pend_c;
  logic rs2_pend_c;
  logic rd_pend_c;
  logic raw_c;
  logic waw_c;
  logic hazard_c;
  logic issue_c;
  logic bubble_c;
  logic stall_c;
  logic set_en_c;

  assign set_en_c = issue_c && is_live(dif.rd_valid, dif.rd);

  reg_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (set_en_c),
    .set_idx    (dif.rd),
    .clr_en     (dif.wb_valid),
    .clr_idx    (dif.wb_rd),
    .rs1_idx    (dif.rs1),
    .rs2_idx    (dif.rs2),
    .rd_idx     (dif.rd),
    .rs1_pend_c (rs1_pend_c),
    .rs2_pend_c (rs2_pend_c),
    .rd_pend_c  (rd_pend_c)
  );

  // Zero-latency hazard detection on the instruction currently in decode.
  always_comb begin
    raw_c    = (is_live(dif.rs1_valid, dif.rs1) && rs1_pend_c) ||
               (is_live(dif.rs2_valid, dif.rs2) && rs2_pend_c);
    waw_c    = is_live(dif.rd_valid, dif.rd) && rd_pend_c;
    hazard_c = dif.id_valid && (raw_c || waw_c);
  end

  // FSM state and flush counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state; any redirect (re)starts the flush window.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (dif.redirect) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else if (hazard_c) begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (dif.redirect) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end else if (!hazard_c) begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (dif.redirect) begin
          flush_cnt_d = FLUSH_LOAD;
        end else if (flush_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Buffer controls: bubble unless a hazard-free valid instruction may issue.
  always_comb begin
    issue_c  = 1'b0;
    bubble_c = 1'b1;
    stall_c  = 1'b0;
    if ((state_q == ST_FLUSH) || dif.redirect) begin
      stall_c = 1'b0;
    end else if (hazard_c) begin
      stall_c = 1'b1;
    end else if (dif.id_valid) begin
      issue_c  = 1'b1;
      bubble_c = 1'b0;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign dif.issue     = issue_c;
  assign dif.bubble    = bubble_c;
  assign dif.stall     = stall_c;
  assign dif.flushing  = (state_q == ST_FLUSH);
  assign dif.stall_cnt = stall_cnt_q;

endmodule
